// File: rtl/image_upscale_replicate.sv
// Streaming nearest-neighbour upscaler: repeats each pixel 2^SCALE_LOG2 times per line
// and replays each line from a line buffer. Define UPSCALE_ERR_CNT_EN to add the err_cnt port.
module image_upscale_replicate #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int SCALE_LOG2 = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_sof,
   input  logic                  s_eol,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [15:0]           m_x,
   output logic [15:0]           m_y,
   output logic                  m_sof,
   output logic                  m_eol
`ifdef UPSCALE_ERR_CNT_EN
   ,output logic [15:0]          err_cnt
`endif
);

   localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [15:0] X_LAST    = 16'((IMG_WIDTH << SCALE_LOG2) - 1);
   localparam logic [15:0] Y_LAST    = 16'((IMG_HEIGHT << SCALE_LOG2) - 1);
   localparam logic [15:0] IN_X_LAST = 16'(IMG_WIDTH - 1);
   localparam logic [15:0] IN_Y_LAST = 16'(IMG_HEIGHT - 1);
   localparam logic [15:0] IN_X_SOF_NEXT = (IMG_WIDTH > 1) ? 16'd1 : 16'd0;
   localparam logic [SCALE_LOG2-1:0] REP_LAST = '1;

   typedef enum logic {LINE_IN, REPLAY} state_t;

   state_t                  state_q, state_d;
   logic                    m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
   logic [15:0]             m_x_q, m_x_d, m_y_q, m_y_d;
   logic                    m_sof_q, m_sof_d, m_eol_q, m_eol_d;
   logic [SCALE_LOG2-1:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [15:0]             in_x_q, in_x_d, in_y_q, in_y_d;
   logic [AW-1:0]           rd_x_q, rd_x_d;
   logic                    ready_q;
   logic [DATA_WIDTH-1:0]   line_q [IMG_WIDTH];

   logic        out_xfer, in_xfer, resync, load;
   logic [15:0] nx, ny;

   assign out_xfer = m_valid_q && m_ready;
   // The last copy of a line's final pixel must not overlap a new input: replay follows it.
   assign s_ready  = ready_q && (state_q == LINE_IN) &&
                     (!m_valid_q || (m_ready && (h_cnt_q == REP_LAST) && !m_eol_q));
   assign in_xfer  = s_valid && s_ready;
   assign resync   = in_xfer && s_sof && ((in_x_q != 16'd0) || (in_y_q != 16'd0));

   assign nx = (m_x_q == X_LAST) ? 16'd0 : m_x_q + 16'd1;
   assign ny = (m_x_q != X_LAST) ? m_y_q : ((m_y_q == Y_LAST) ? 16'd0 : m_y_q + 16'd1);

   always_comb begin
      state_d   = state_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_x_d     = m_x_q;
      m_y_d     = m_y_q;
      m_sof_d   = m_sof_q;
      m_eol_d   = m_eol_q;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      in_x_d    = in_x_q;
      in_y_d    = in_y_q;
      rd_x_d    = rd_x_q;
      load      = 1'b0;

      if (out_xfer) begin
         m_x_d = nx;
         m_y_d = ny;
      end

      case (state_q)
         LINE_IN: begin
            if (in_xfer) begin
               m_valid_d = 1'b1;
               m_data_d  = s_data;
               h_cnt_d   = '0;
               load      = 1'b1;
               if (resync) begin
                  in_x_d  = IN_X_SOF_NEXT;
                  in_y_d  = 16'd0;
                  m_x_d   = 16'd0;
                  m_y_d   = 16'd0;
                  v_cnt_d = '0;
               end else if (in_x_q == IN_X_LAST) begin
                  in_x_d = 16'd0;
                  in_y_d = (in_y_q == IN_Y_LAST) ? 16'd0 : in_y_q + 16'd1;
               end else begin
                  in_x_d = in_x_q + 16'd1;
               end
            end else if (out_xfer) begin
               if (h_cnt_q != REP_LAST) begin
                  h_cnt_d = h_cnt_q + 1'b1;
               end else begin
                  m_valid_d = 1'b0;
                  if (m_eol_q) begin
                     state_d = REPLAY;
                     v_cnt_d = SCALE_LOG2'(1);
                     rd_x_d  = '0;
                  end
               end
            end
         end
         REPLAY: begin
            // An empty register here is the one-cycle read bubble that opens each pass.
            if (!m_valid_q) begin
               m_valid_d = 1'b1;
               m_data_d  = line_q[rd_x_q];
               h_cnt_d   = '0;
               rd_x_d    = rd_x_q + 1'b1;
               load      = 1'b1;
            end else if (out_xfer) begin
               if (h_cnt_q != REP_LAST) begin
                  h_cnt_d = h_cnt_q + 1'b1;
               end else if (m_eol_q) begin
                  m_valid_d = 1'b0;
                  rd_x_d    = '0;
                  if (v_cnt_q == REP_LAST) begin
                     state_d = LINE_IN;
                     v_cnt_d = '0;
                  end else begin
                     v_cnt_d = v_cnt_q + 1'b1;
                  end
               end else begin
                  m_data_d = line_q[rd_x_q];
                  h_cnt_d  = '0;
                  rd_x_d   = rd_x_q + 1'b1;
                  load     = 1'b1;
               end
            end
         end
         default: state_d = LINE_IN;
      endcase

      if (out_xfer || load) begin
         m_sof_d = (m_x_d == 16'd0) && (m_y_d == 16'd0);
         m_eol_d = (m_x_d == X_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= LINE_IN;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_x_q     <= 16'd0;
         m_y_q     <= 16'd0;
         m_sof_q   <= 1'b0;
         m_eol_q   <= 1'b0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         in_x_q    <= 16'd0;
         in_y_q    <= 16'd0;
         rd_x_q    <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_x_q     <= m_x_d;
         m_y_q     <= m_y_d;
         m_sof_q   <= m_sof_d;
         m_eol_q   <= m_eol_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         in_x_q    <= in_x_d;
         in_y_q    <= in_y_d;
         rd_x_q    <= rd_x_d;
         ready_q   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (in_xfer) line_q[resync ? AW'(0) : in_x_q[AW-1:0]] <= s_data;
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_x     = m_x_q;
   assign m_y     = m_y_q;
   assign m_sof   = m_sof_q;
   assign m_eol   = m_eol_q;

`ifdef UPSCALE_ERR_CNT_EN
   logic [15:0] err_cnt_q;
   logic        err_hit;

   assign err_hit = in_xfer && ((s_eol != (in_x_q == IN_X_LAST)) || resync);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt_q <= 16'd0;
      end else if (err_hit && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_s_eol;
   assign unused_s_eol = s_eol;
`endif

endmodule

// File: tb/tb_image_upscale_replicate.sv
// Randomized bench for image_upscale_replicate (4x2 image, 2x scale) against a
// line-level reference model; err_cnt is checked when UPSCALE_ERR_CNT_EN is defined.
module tb_image_upscale_replicate;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int SL = 1;
   localparam int S  = 1 << SL;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          s_sof = 1'b0;
   logic          s_eol = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic [15:0]   m_x, m_y;
   logic          m_sof, m_eol;
`ifdef UPSCALE_ERR_CNT_EN
   logic [15:0]   err_cnt;
`endif

   always #5 clk = ~clk;

   image_upscale_replicate #(
      .DATA_WIDTH (DW),
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .SCALE_LOG2 (SL)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_sof   (s_sof),
      .s_eol   (s_eol),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_x     (m_x),
      .m_y     (m_y),
      .m_sof   (m_sof),
      .m_eol   (m_eol)
`ifdef UPSCALE_ERR_CNT_EN
      ,.err_cnt (err_cnt)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [9:0]    src[$];
   logic [41:0]   expq[$];
   int            out_cyc[$];
   int            in_cyc[$];
   int            cyc = 0;
   int            pv = 100;
   int            pr = 100;
   int            mdl_x = 0;
   int            mdl_y = 0;
   int            mdl_err = 0;
   logic [DW-1:0] mdl_line [W];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h at cycle %0d", tag, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [DW-1:0] d, input int x, input int y);
      expq.push_back({d, 16'(x), 16'(y), (x == 0 && y == 0), (x == W*S-1)});
   endtask

   // Reference: each accepted pixel yields S copies on its live row; a completed line
   // additionally yields S-1 replayed rows.
   task automatic mdl_in(input logic [9:0] e);
      logic [DW-1:0] d;
      bit sof, eol, rs;
      d   = e[9:2];
      sof = e[1];
      eol = e[0];
      rs  = sof && (mdl_x != 0 || mdl_y != 0);
      if (rs || (eol != (mdl_x == W-1))) begin
         if (mdl_err < 65535) mdl_err++;
      end
      if (rs) begin
         mdl_x = 0;
         mdl_y = 0;
      end
      mdl_line[mdl_x] = d;
      for (int k = 0; k < S; k++) push_exp(d, mdl_x*S + k, mdl_y*S);
      if (mdl_x == W-1) begin
         for (int r = 1; r < S; r++)
            for (int x = 0; x < W*S; x++) push_exp(mdl_line[x/S], x, mdl_y*S + r);
         mdl_x = 0;
         mdl_y = (mdl_y + 1) % H;
      end else begin
         mdl_x++;
      end
   endtask

   task automatic mdl_reset();
      expq.delete();
      src.delete();
      mdl_x   = 0;
      mdl_y   = 0;
      mdl_err = 0;
   endtask

   task automatic step();
      @(negedge clk);
      if (src.size() != 0 && $urandom_range(99) < pv) begin
         s_valid = 1'b1;
         {s_data, s_sof, s_eol} = src[0];
      end else begin
         s_valid = 1'b0;
         s_data  = DW'($urandom_range(255));
         s_sof   = 1'b0;
         s_eol   = 1'b0;
      end
      m_ready = ($urandom_range(99) < pr);
      #1;
      if (m_valid) begin
         if (expq.size() == 0) begin
            chk("unexpected_out", {m_data, m_x, m_y, m_sof, m_eol}, 64'hDEAD);
         end else begin
            chk("out_pixel", {m_data, m_x, m_y, m_sof, m_eol}, expq[0]);
            if (m_ready) begin
               void'(expq.pop_front());
               out_cyc.push_back(cyc);
            end
         end
      end
      if (s_valid && s_ready) begin
         mdl_in(src[0]);
         void'(src.pop_front());
         in_cyc.push_back(cyc);
      end
      cyc++;
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while ((src.size() != 0 || expq.size() != 0) && n < bound) begin
         step();
         n++;
      end
      chk("drained", src.size() + expq.size(), 0);
   endtask

   task automatic push_px(input int d, input bit sof, input bit eol);
      src.push_back({DW'(d), sof, eol});
   endtask

   task automatic push_line(input int d0, input int d1, input int d2, input int d3, input bit sof);
      push_px(d0, sof, 1'b0);
      push_px(d1, 1'b0, 1'b0);
      push_px(d2, 1'b0, 1'b0);
      push_px(d3, 1'b0, 1'b1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_data"},  m_data,  0);
      chk({tag, "_m_x"},     m_x,     0);
      chk({tag, "_m_y"},     m_y,     0);
      chk({tag, "_m_sof"},   m_sof,   0);
      chk({tag, "_m_eol"},   m_eol,   0);
      chk({tag, "_s_ready"}, s_ready, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;

      // Reset state
      #12;
      chk_reset_outputs("rst");
`ifdef UPSCALE_ERR_CNT_EN
      chk("rst_err_cnt", err_cnt, 0);
`endif
      @(negedge clk);
      rst = 1'b1;

      // Line 10..40 then 50..80 with full throughput: exact latency and bubble timing
      pv = 100; pr = 100;
      out_cyc.delete(); in_cyc.delete();
      push_line(10, 20, 30, 40, 1'b1);
      push_line(50, 60, 70, 80, 1'b0);
      drain(500);
      chk("s1_n_out", out_cyc.size(), 32);
      if (out_cyc.size() >= 16 && in_cyc.size() >= 5) begin
         chk("s1_latency",      out_cyc[0] - in_cyc[0], 1);
         chk("s1_row0_burst",   out_cyc[7] - out_cyc[0], 7);
         chk("s1_bubble",       out_cyc[8] - out_cyc[7], 2);
         chk("s1_row1_burst",   out_cyc[15] - out_cyc[8], 7);
         chk("s1_no_in_replay", in_cyc[4] - out_cyc[15], 1);
      end

      // Same frame under 50% downstream stalls
      pv = 100; pr = 50;
      push_line(10, 20, 30, 40, 1'b1);
      push_line(50, 60, 70, 80, 1'b0);
      drain(2000);

      // Full frame then start of the next frame at pixel 9
      pv = 70; pr = 70;
      push_line(1, 2, 3, 4, 1'b1);
      push_line(5, 6, 7, 8, 1'b0);
      push_line(9, 10, 11, 12, 1'b1);
      push_line(13, 14, 15, 16, 1'b0);
      drain(2000);

      // Resync: sof on the 3rd pixel of line 1
      pv = 80; pr = 60;
      push_line(21, 22, 23, 24, 1'b1);
      push_px(25, 1'b0, 1'b0);
      push_px(26, 1'b0, 1'b0);
      push_px(99, 1'b1, 1'b0);
      push_px(100, 1'b0, 1'b0);
      push_px(101, 1'b0, 1'b0);
      push_px(102, 1'b0, 1'b1);
      push_line(103, 104, 105, 106, 1'b0);
      drain(2000);
`ifdef UPSCALE_ERR_CNT_EN
      chk("err_after_resync", err_cnt, mdl_err);
`endif

      // Misplaced s_eol twice, then a resync carrying a consistent s_eol
      pv = 90; pr = 80;
      push_px(31, 1'b1, 1'b0);
      push_px(32, 1'b0, 1'b0);
      push_px(33, 1'b0, 1'b1);
      push_px(34, 1'b0, 1'b0);
      drain(1000);
`ifdef UPSCALE_ERR_CNT_EN
      chk("err_eol_pair", err_cnt, mdl_err);
`endif
      push_px(35, 1'b0, 1'b0);
      push_px(36, 1'b1, 1'b0);
      push_px(37, 1'b0, 1'b0);
      push_px(38, 1'b0, 1'b1);
      push_line(39, 40, 41, 42, 1'b0);
      drain(2000);
`ifdef UPSCALE_ERR_CNT_EN
      chk("err_eol_resync", err_cnt, mdl_err);
`endif

      // Reset asserted while a replayed row is being emitted
      pv = 100; pr = 100;
      push_line(51, 52, 53, 54, 1'b1);
      guard = 0;
      while (!(m_valid === 1'b1 && m_y[0] === 1'b1) && guard < 200) begin
         step();
         guard++;
      end
      chk("s5_reached_replay", guard < 200, 1);
      rst = 1'b0;
      #1;
      chk_reset_outputs("s5_rst");
`ifdef UPSCALE_ERR_CNT_EN
      chk("s5_err_cnt", err_cnt, 0);
`endif
      s_valid = 1'b0;
      m_ready = 1'b1;
      mdl_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("s5_s_ready_after_rst", s_ready, 1);
      chk("s5_m_valid_after_rst", m_valid, 0);

      // Random frames after recovery
      pv = 60; pr = 60;
      for (int f = 0; f < 3; f++)
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
               push_px($urandom_range(255), (x == 0 && y == 0), (x == W-1));
      drain(4000);
`ifdef UPSCALE_ERR_CNT_EN
      chk("err_final", err_cnt, mdl_err);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
